mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-memory (DM) stage of the MIPS pipeline. It serializes requests, gives DM strict priority, handles IF cancellation on taken branches and jumps, and recovers from a non-responding memory with a timeout. It sits between the IF/MEM pipeline stages and the memory model, and replaces the separate instruction and data RAM ports.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the MIPS IF and DM stages. DM has
// strict priority, IF fetches can be cancelled by a flush, and a wait counter
// aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err_timeout
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       drop;
  logic [7:0] wait_cnt;
  logic       if_drop;
  logic       timed_out;

  // A flush arriving in the same cycle as mem_ack must still suppress if_ack.
  assign if_drop   = drop | if_flush;
  assign timed_out = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, because their reset value
      // of zero is visible on the ports and software may rely on it.
      state       <= IDLE;
      drop        <= 1'b0;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_ack      <= 1'b0;
      dm_rdata    <= '0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the acks default low here so
      // that setting them on entry to RESP yields a single-cycle pulse.
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dm_req) begin
            state     <= DM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wait_cnt  <= '0;
          end else if (if_req && !if_flush) begin
            state    <= IF_BUSY;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            wait_cnt <= '0;
          end
        end
        IF_BUSY: begin
          if (if_flush) drop <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (!if_drop) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timed_out) begin
              mem_req     <= 1'b0;
              err_timeout <= 1'b1;
              state       <= RESP;
              if (!if_drop) begin
                if_rdata <= '0;
                if_ack   <= 1'b1;
              end
            end
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= RESP;
            dm_rdata <= mem_rdata;
            dm_ack   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timed_out) begin
              mem_req     <= 1'b0;
              err_timeout <= 1'b1;
              state       <= RESP;
              dm_rdata    <= '0;
              dm_ack      <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          drop  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory with programmable latency
// plus scoreboard queues for memory transactions and requester read data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam logic [31:0] STORE_RET = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (TIMEOUT = 255)
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        if_ack, dm_ack, mem_req, mem_we, mem_ack, err_timeout;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  // second instance with TIMEOUT = 4, memory side driven by hand
  logic        t_dm_req = 1'b0, t_mem_ack = 1'b0;
  logic [31:0] t_dm_addr = '0, t_mem_rdata = '0;
  logic        t_if_ack, t_dm_ack, t_mem_req, t_mem_we, t_err_timeout;
  logic [31:0] t_if_rdata, t_dm_rdata, t_mem_addr, t_mem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout)
  );

  mem_port_arbiter #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'h0), .if_flush(1'b0),
    .if_ack(t_if_ack), .if_rdata(t_if_rdata),
    .dm_req(t_dm_req), .dm_we(1'b0), .dm_addr(t_dm_addr), .dm_wdata(32'h0),
    .dm_ack(t_dm_ack), .dm_rdata(t_dm_rdata),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata),
    .err_timeout(t_err_timeout)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t    exp_mem_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] model_mem [256];
  int          mem_delay = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // Memory model: acks mem_delay cycles after mem_req rises (0 = same cycle).
  initial begin
    int wait_c;
    mem_txn_t e;
    wait_c    = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    model_mem[16] = 32'h2008_000A;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack || !mem_req) begin
        mem_ack = 1'b0;
        wait_c  = 0;
      end else if (wait_c >= mem_delay) begin
        mem_ack = 1'b1;
        vectors++;
        if (exp_mem_q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_txn: unexpected access we=%b addr=%h", mem_we, mem_addr);
        end else begin
          e = exp_mem_q.pop_front();
          if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
            miscompares++;
            $display("FAIL mem_txn: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
          end
        end
        if (mem_we) begin
          model_mem[mem_addr[9:2]] = mem_wdata;
          mem_rdata = STORE_RET;
        end else begin
          mem_rdata = model_mem[mem_addr[9:2]];
        end
      end else begin
        wait_c++;
      end
    end
  end

  // Ack monitor: pops expected read data, checks pulse width and exclusivity.
  initial begin
    logic prev_if, prev_dm;
    logic [31:0] e;
    prev_if = 1'b0;
    prev_dm = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (if_ack || dm_ack)) begin
        vectors++;
        if (if_ack && dm_ack) begin
          miscompares++;
          $display("FAIL ack_overlap: if_ack and dm_ack both 1, want at most one");
        end
        if ((if_ack && prev_if) || (dm_ack && prev_dm)) begin
          miscompares++;
          $display("FAIL ack_width: ack high 2 cycles, want 1");
        end
      end
      if (rst_n && if_ack) begin
        vectors++;
        if (exp_if_q.size() == 0) begin
          miscompares++;
          $display("FAIL if_ack: unexpected ack, if_rdata=%h", if_rdata);
        end else begin
          e = exp_if_q.pop_front();
          if (if_rdata !== e) begin
            miscompares++;
            $display("FAIL if_rdata: got %h want %h", if_rdata, e);
          end
        end
      end
      if (rst_n && dm_ack) begin
        vectors++;
        if (exp_dm_q.size() == 0) begin
          miscompares++;
          $display("FAIL dm_ack: unexpected ack, dm_rdata=%h", dm_rdata);
        end else begin
          e = exp_dm_q.pop_front();
          if (dm_rdata !== e) begin
            miscompares++;
            $display("FAIL dm_rdata: got %h want %h", dm_rdata, e);
          end
        end
      end
      prev_if = if_ack & rst_n;
      prev_dm = dm_ack & rst_n;
    end
  end

  // One access on the main instance; called at a negedge, returns at the ack.
  task automatic do_access(input string name, input bit is_dm, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int req_cycles);
    mem_txn_t t;
    bit done;
    t.we = we; t.addr = addr; t.wdata = wdata;
    exp_mem_q.push_back(t);
    if (is_dm) begin
      exp_dm_q.push_back(we ? STORE_RET : model_mem[addr[9:2]]);
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      exp_if_q.push_back(model_mem[addr[9:2]]);
      if_req = 1'b1; if_addr = addr;
    end
    lat = 0; req_cycles = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_req) req_cycles++;
      if (is_dm ? dm_ack : if_ack) done = 1'b1;
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s: no ack within %0d cycles, want ack", name, lat);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({if_ack, dm_ack, mem_req, mem_we, err_timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {if_ack, dm_ack, mem_req, mem_we, err_timeout});
    end
    vectors++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
  endtask

  task automatic test_fetch();
    int lat, rc;
    mem_delay = 1;
    do_access("fetch", 1'b0, 1'b0, 32'h40, 32'h0, lat, rc);
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL fetch_latency: got %0d want 3", lat);
    end
    vectors++;
    if (rc !== 2) begin
      miscompares++;
      $display("FAIL fetch_req_cycles: got %0d want 2", rc);
    end
    vectors++;
    if (if_rdata !== 32'h2008_000A) begin
      miscompares++;
      $display("FAIL fetch_rdata: got %h want 2008000a", if_rdata);
    end
  endtask

  task automatic test_contention();
    mem_txn_t t;
    int dm_c, if_c, lat, rc;
    mem_delay = 0;
    t.we = 1'b1; t.addr = 32'h100; t.wdata = 32'h1234_5678; exp_mem_q.push_back(t);
    t.we = 1'b0; t.addr = 32'h80;  t.wdata = 32'h0;         exp_mem_q.push_back(t);
    exp_dm_q.push_back(STORE_RET);
    exp_if_q.push_back(model_mem[32]);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h80;
    dm_c = -1; if_c = -1;
    for (int c = 1; c <= 20 && if_c < 0; c++) begin
      @(negedge clk);
      if (dm_ack) begin dm_c = c; dm_req = 1'b0; dm_we = 1'b0; end
      if (if_ack) begin if_c = c; if_req = 1'b0; end
    end
    vectors++;
    if (dm_c !== 2 || if_c !== 5) begin
      miscompares++;
      $display("FAIL contention_order: dm_ack@%0d if_ack@%0d, want 2 and 5", dm_c, if_c);
    end
    if_req = 1'b0; dm_req = 1'b0;
    do_access("readback", 1'b1, 1'b0, 32'h100, 32'h0, lat, rc);
    vectors++;
    if (dm_rdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL readback: got %h want 12345678", dm_rdata);
    end
  endtask

  task automatic test_flush();
    mem_txn_t t;
    logic [31:0] prev_rdata;
    int dm_c;
    bit if_seen;
    // flush in IDLE blocks the grant
    if_req = 1'b1; if_addr = 32'h48; if_flush = 1'b1;
    @(negedge clk);
    if_req = 1'b0; if_flush = 1'b0;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: mem_req got %b want 0", mem_req);
    end
    @(negedge clk);
    // flush during IF_BUSY with a DM request waiting
    mem_delay = 3;
    prev_rdata = if_rdata;
    t.we = 1'b0; t.addr = 32'h44; t.wdata = 32'h0; exp_mem_q.push_back(t);
    t.addr = 32'h20; exp_mem_q.push_back(t);
    exp_dm_q.push_back(model_mem[8]);
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_grant: mem_req got %b want 1", mem_req);
    end
    if_flush = 1'b1; if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    dm_c = -1; if_seen = 1'b0;
    for (int c = 1; c <= 30 && dm_c < 0; c++) begin
      @(negedge clk);
      if_flush = 1'b0;
      if (if_ack) if_seen = 1'b1;
      if (dm_ack) begin dm_c = c; dm_req = 1'b0; end
    end
    dm_req = 1'b0;
    vectors++;
    if (if_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_ack: if_ack seen %b want 0", if_seen);
    end
    vectors++;
    if (if_rdata !== prev_rdata) begin
      miscompares++;
      $display("FAIL flush_rdata: got %h want %h", if_rdata, prev_rdata);
    end
    vectors++;
    if (dm_c !== 10) begin
      miscompares++;
      $display("FAIL flush_dm_grant: dm_ack@%0d want 10", dm_c);
    end
  endtask

  task automatic test_back_to_back();
    mem_txn_t t;
    int c1, c2;
    mem_delay = 0;
    t.we = 1'b0; t.wdata = 32'h0;
    t.addr = 32'h10; exp_mem_q.push_back(t);
    t.addr = 32'h14; exp_mem_q.push_back(t);
    exp_dm_q.push_back(model_mem[4]);
    exp_dm_q.push_back(model_mem[5]);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    c1 = -1; c2 = -1;
    for (int c = 1; c <= 20 && c2 < 0; c++) begin
      @(negedge clk);
      if (dm_ack && c1 < 0) begin c1 = c; dm_addr = 32'h14; end
      else if (dm_ack) begin c2 = c; dm_req = 1'b0; end
    end
    dm_req = 1'b0;
    vectors++;
    if (c1 !== 2 || c2 - c1 !== 3) begin
      miscompares++;
      $display("FAIL back_to_back: acks@%0d,%0d want 2,5", c1, c2);
    end
  endtask

  // Drives one load into the TIMEOUT=4 instance, optionally answering it.
  task automatic t_access(input bit respond, input logic [31:0] data,
                          output int rc, output bit acked);
    t_dm_req = 1'b1; t_dm_addr = 32'h30;
    rc = 0; acked = 1'b0;
    for (int c = 0; c < 20 && !acked; c++) begin
      @(negedge clk);
      if (t_mem_ack) t_mem_ack = 1'b0;
      else if (t_mem_req && respond) begin t_mem_ack = 1'b1; t_mem_rdata = data; end
      if (t_mem_req) rc++;
      if (t_dm_ack) acked = 1'b1;
    end
    t_dm_req = 1'b0;
    t_mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int rc;
    bit acked;
    t_access(1'b1, 32'hCAFE_F00D, rc, acked);
    vectors++;
    if (!acked || t_dm_rdata !== 32'hCAFE_F00D || t_err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL to_good1: ack=%b rdata=%h err=%b want 1 cafef00d 0", acked, t_dm_rdata, t_err_timeout);
    end
    @(negedge clk);
    t_access(1'b0, 32'h0, rc, acked);
    vectors++;
    if (rc !== 4) begin
      miscompares++;
      $display("FAIL to_req_cycles: got %0d want 4", rc);
    end
    vectors++;
    if (!acked || t_dm_rdata !== 32'h0 || t_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL to_abort: ack=%b rdata=%h mem_req=%b want 1 0 0", acked, t_dm_rdata, t_mem_req);
    end
    vectors++;
    if (t_err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL to_err_set: got %b want 1", t_err_timeout);
    end
    @(negedge clk);
    t_access(1'b1, 32'h0BAD_BEEF, rc, acked);
    vectors++;
    if (!acked || t_dm_rdata !== 32'h0BAD_BEEF || t_err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL to_sticky: ack=%b rdata=%h err=%b want 1 0badbeef 1", acked, t_dm_rdata, t_err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit ack_seen;
    int lat, rc;
    mem_delay = 6;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h24;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_busy: mem_req got %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: mem_req got %b want 0", mem_req);
    end
    dm_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dm_ack) ack_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dm_ack) ack_seen = 1'b1;
    end
    vectors++;
    if (ack_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_ack: dm_ack seen %b want 0", ack_seen);
    end
    vectors++;
    if ({if_ack, dm_ack, mem_req, mem_we, err_timeout, t_err_timeout} !== 6'b0 ||
        {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      miscompares++;
      $display("FAIL rst_outputs: ctrl=%b data=%h want all 0",
               {if_ack, dm_ack, mem_req, mem_we, err_timeout, t_err_timeout},
               {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    mem_delay = 0;
    do_access("post_reset", 1'b1, 1'b0, 32'h8, 32'h0, lat, rc);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL post_reset_latency: got %0d want 2", lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    @(negedge clk);
    test_contention();
    @(negedge clk);
    test_flush();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_timeout();
    @(negedge clk);
    test_reset_mid();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_mem_q.size() != 0 || exp_if_q.size() != 0 || exp_dm_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: left mem=%0d if=%0d dm=%0d want 0",
               exp_mem_q.size(), exp_if_q.size(), exp_dm_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
